mult_8x8_acc_stage: RTL

//  Downstream consumer of the 8x8 unsigned multiplier's 16-bit product stream.

---
 rtl/mult_acc_pkg.sv | 19 +
 rtl/mult_8x8_acc_stage.sv | 100 ++++++++++
 2 files changed

// File: rtl/mult_acc_pkg.sv
// Shared types and defaults for the product accumulation stage.
// CNT_W is derived so a counter can hold MAX_LEN itself, not just MAX_LEN-1.
package mult_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W_D  = 16;
    localparam int ACC_W_D   = 24;
    localparam int MAX_LEN_D = 256;

    function automatic int cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/mult_8x8_acc_stage.sv
// Sums groups of multiplier products and presents each sum with its beat count.
// A group closes on prod_last or after MAX_LEN beats; the result is held until taken.
module mult_8x8_acc_stage
    import mult_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_D,
    parameter int ACC_W   = ACC_W_D,
    parameter int MAX_LEN = MAX_LEN_D,
    parameter int CNT_W   = cnt_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_forced
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             forced;

    logic             beat;
    logic [ACC_W:0]   sum_c;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_max;

    assign beat    = prod_valid & prod_ready;
    assign sum_c   = {1'b0, acc} + (ACC_W+1)'(prod_data);
    assign cnt_inc = cnt + 1'b1;
    assign at_max  = (cnt_inc == CNT_W'(MAX_LEN));

    // Result fields come straight from the group registers, which freeze in HOLD.
    assign out_valid  = (state == HOLD);
    assign out_sum    = acc;
    assign out_count  = cnt;
    assign out_ovf    = ovf;
    assign out_forced = forced;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            forced     <= 1'b0;
            prod_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prod_ready <= 1'b1;
                    if (beat) begin
                        acc <= ACC_W'(prod_data);
                        cnt <= CNT_W'(1);
                        ovf <= 1'b0;
                        if (prod_last || MAX_LEN == 1) begin
                            state      <= HOLD;
                            prod_ready <= 1'b0;
                            forced     <= ~prod_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= sum_c[ACC_W-1:0];
                        cnt <= cnt_inc;
                        ovf <= ovf | sum_c[ACC_W];
                        // prod_last wins over the length limit when both hit together
                        if (prod_last || at_max) begin
                            state      <= HOLD;
                            prod_ready <= 1'b0;
                            forced     <= ~prod_last;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        prod_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    prod_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
